// File: rtl/run_seq_pkg.sv
// Shared types and constants for the multi-round run sequencer.
package run_seq_pkg;

    localparam int unsigned DEF_ROUND_W = 8;
    localparam int unsigned DEF_CYCLE_W = 32;
    localparam int unsigned DEF_SETTLE  = 5;

    // Saturation ceiling of a default-width cycle counter
    localparam logic [DEF_CYCLE_W-1:0] DEF_CYCLE_MAX = '1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LOAD      = 4'd1,
        ST_SETTLE    = 4'd2,
        ST_WAIT_IDLE = 4'd3,
        ST_RUN       = 4'd4,
        ST_COMPUTE   = 4'd5,
        ST_CHECK     = 4'd6,
        ST_DONE      = 4'd7,
        ST_ABORT     = 4'd8
    } state_t;

    // True while a sequence is in flight
    function automatic logic is_busy_state(state_t s);
        return !(s inside {ST_IDLE, ST_DONE, ST_ABORT});
    endfunction

endpackage

// File: rtl/run_sequencer_if.sv
// Handshake bundle between the sequencer, the harness glue and the DUT run pins.
interface run_seq_if;
    logic load_req;
    logic load_done;
    logic dut_run;
    logic dut_busy;
    logic check_req;
    logic check_done;

    modport master (
        output load_req, dut_run, check_req,
        input  load_done, dut_busy, check_done
    );

    modport slave (
        input  load_req, dut_run, check_req,
        output load_done, dut_busy, check_done
    );
endinterface

// File: rtl/run_sequencer_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);
    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Clear restarts from zero; if also enabled, that cycle already counts as one
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = en ? WIDTH'(1) : '0;
        end else if (en && (cnt_q != MAX)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/run_sequencer.sv
// Multi-round run controller: load -> settle -> run/busy handshake -> measure -> check.
//
// state      | meaning
// IDLE       | waiting for start, nothing run yet
// LOAD       | load_req high until load_done
// SETTLE     | fixed idle gap after the load
// WAIT_IDLE  | hold off until the DUT reports not busy
// RUN        | dut_run high until busy is seen
// COMPUTE    | DUT working, round counter running
// CHECK      | check_req high until check_done
// DONE       | all rounds finished
// ABORT      | global timeout hit
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int ROUND_W       = DEF_ROUND_W,
    parameter int CYCLE_W       = DEF_CYCLE_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic               start,
    input  logic [ROUND_W-1:0] num_rounds,
    input  logic [CYCLE_W-1:0] timeout_cycles,
    run_seq_if.master          bus,
    output logic [ROUND_W-1:0] round_idx,
    output logic [CYCLE_W-1:0] round_cycles,
    output logic               round_valid,
    output logic [CYCLE_W-1:0] total_cycles,
    output logic               seq_busy,
    output logic               done,
    output logic               timeout_err
);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_CYCLES - 1);

    state_t state_q, state_d;

    logic [ROUND_W-1:0] num_rounds_q, num_rounds_d;
    logic [CYCLE_W-1:0] timeout_q, timeout_d;
    logic [ROUND_W-1:0] round_idx_q, round_idx_d;
    logic [CYCLE_W-1:0] round_cycles_q, round_cycles_d;
    logic               round_valid_q, round_valid_d;
    logic [SET_W-1:0]   settle_q, settle_d;

    logic [CYCLE_W-1:0] round_cnt;
    logic [CYCLE_W-1:0] total_cnt;

    logic busy_st;
    logic accept;
    logic last_round;
    logic timeout_hit;
    logic round_clr;
    logic round_en;

    assign busy_st    = is_busy_state(state_q);
    assign accept     = start && !busy_st;
    assign last_round = (round_idx_q == (num_rounds_q - ROUND_W'(1)));

    // Fires on the busy cycle whose increment brings total_cycles up to the limit,
    // so ABORT is entered with total_cycles equal to timeout_cycles.
    assign timeout_hit = busy_st && (timeout_q != '0) &&
                         (total_cnt >= (timeout_q - CYCLE_W'(1)));

    // Round counter restarts on WAIT_IDLE exit so the first RUN cycle reads 1
    assign round_clr = (state_q == ST_WAIT_IDLE) && !bus.dut_busy;
    assign round_en  = (state_q == ST_RUN) || (state_q == ST_COMPUTE) || round_clr;

    sat_counter #(.WIDTH(CYCLE_W)) u_round_cnt (
        .clk     (clk),
        .reset_b (reset_b),
        .clr     (round_clr),
        .en      (round_en),
        .cnt     (round_cnt)
    );

    sat_counter #(.WIDTH(CYCLE_W)) u_total_cnt (
        .clk     (clk),
        .reset_b (reset_b),
        .clr     (accept),
        .en      (busy_st),
        .cnt     (total_cnt)
    );

    // State register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; timeout overrides every other transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ABORT: begin
                if (start) state_d = (num_rounds == '0) ? ST_DONE : ST_LOAD;
            end
            ST_LOAD:      if (bus.load_done)   state_d = ST_SETTLE;
            ST_SETTLE:    if (settle_q == '0)  state_d = ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (!bus.dut_busy)   state_d = ST_RUN;
            ST_RUN:       if (bus.dut_busy)    state_d = ST_COMPUTE;
            ST_COMPUTE:   if (!bus.dut_busy)   state_d = ST_CHECK;
            ST_CHECK: begin
                if (bus.check_done) state_d = last_round ? ST_DONE : ST_LOAD;
            end
            default:      state_d = ST_IDLE;
        endcase
        if (timeout_hit) state_d = ST_ABORT;
    end

    // Datapath next values: latched config, round index, settle timer, measurement
    always_comb begin
        num_rounds_d   = num_rounds_q;
        timeout_d      = timeout_q;
        round_idx_d    = round_idx_q;
        round_cycles_d = round_cycles_q;
        round_valid_d  = 1'b0;
        settle_d       = settle_q;

        if (accept) begin
            num_rounds_d = num_rounds;
            timeout_d    = timeout_cycles;
            round_idx_d  = '0;
        end

        if (state_q == ST_LOAD) begin
            settle_d = SETTLE_INIT;
        end else if ((state_q == ST_SETTLE) && (settle_q != '0)) begin
            settle_d = settle_q - SET_W'(1);
        end

        if ((state_q == ST_COMPUTE) && !bus.dut_busy && !timeout_hit) begin
            round_cycles_d = round_cnt;
            round_valid_d  = 1'b1;
        end

        if ((state_q == ST_CHECK) && bus.check_done && !last_round && !timeout_hit) begin
            round_idx_d = round_idx_q + ROUND_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            num_rounds_q   <= '0;
            timeout_q      <= '0;
            round_idx_q    <= '0;
            round_cycles_q <= '0;
            round_valid_q  <= 1'b0;
            settle_q       <= '0;
        end else begin
            num_rounds_q   <= num_rounds_d;
            timeout_q      <= timeout_d;
            round_idx_q    <= round_idx_d;
            round_cycles_q <= round_cycles_d;
            round_valid_q  <= round_valid_d;
            settle_q       <= settle_d;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        bus.load_req  = (state_q == ST_LOAD);
        bus.dut_run   = (state_q == ST_RUN);
        bus.check_req = (state_q == ST_CHECK);
        seq_busy      = busy_st;
        done          = (state_q == ST_DONE) || (state_q == ST_ABORT);
        timeout_err   = (state_q == ST_ABORT);
    end

    assign round_idx    = round_idx_q;
    assign round_cycles = round_cycles_q;
    assign round_valid  = round_valid_q;
    assign total_cycles = total_cnt;
endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;
    localparam int ROUND_W = 8;
    localparam int CYCLE_W = 32;
    localparam int SETTLE  = 5;

    logic               clk = 1'b0;
    logic               reset_b = 1'b0;
    logic               start = 1'b0;
    logic [ROUND_W-1:0] num_rounds = '0;
    logic [CYCLE_W-1:0] timeout_cycles = '0;
    logic [ROUND_W-1:0] round_idx;
    logic [CYCLE_W-1:0] round_cycles;
    logic               round_valid;
    logic [CYCLE_W-1:0] total_cycles;
    logic               seq_busy;
    logic               done;
    logic               timeout_err;

    run_seq_if bus();

    run_sequencer #(.ROUND_W(ROUND_W), .CYCLE_W(CYCLE_W), .SETTLE_CYCLES(SETTLE)) dut (
        .clk            (clk),
        .reset_b        (reset_b),
        .start          (start),
        .num_rounds     (num_rounds),
        .timeout_cycles (timeout_cycles),
        .bus            (bus),
        .round_idx      (round_idx),
        .round_cycles   (round_cycles),
        .round_valid    (round_valid),
        .total_cycles   (total_cycles),
        .seq_busy       (seq_busy),
        .done           (done),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // harness/DUT model configuration (written by the main sequence only)
    int ld_dly = 0, ck_dly = 0, bz_dly = 1, bz_len = 10;
    bit hang = 0, spur = 0, force_busy = 0, clr_model = 0;

    // model and monitor state (written by the negedge process only)
    int   ph = 0, cnt = 0, ldc = 0, ckc = 0;
    logic busy_m = 0, ld_d = 0, ck_d = 0;
    logic prev_ld = 0, prev_ck = 0;
    int   n_load = 0, n_check = 0, n_valid = 0, n_overlap = 0;
    logic [ROUND_W-1:0] idx_at [0:1023];
    logic [CYCLE_W-1:0] rc_at  [0:1023];

    assign bus.dut_busy   = busy_m | force_busy;
    assign bus.load_done  = ld_d;
    assign bus.check_done = ck_d | (spur & bus.dut_run);

    // Harness responders and DUT busy model, plus output monitors, all on the falling edge
    always @(negedge clk) begin
        if (bus.load_req && !prev_ld) begin idx_at[n_load] = round_idx; n_load++; end
        if (bus.check_req && !prev_ck) n_check++;
        prev_ld = bus.load_req;
        prev_ck = bus.check_req;
        if (bus.dut_run && (bus.load_req || bus.check_req)) n_overlap++;
        if (round_valid) begin rc_at[n_valid] = round_cycles; n_valid++; end

        if (bus.load_req) begin
            if (ldc == ld_dly) ld_d = 1'b1; else begin ld_d = 1'b0; ldc++; end
        end else begin ld_d = 1'b0; ldc = 0; end

        if (bus.check_req) begin
            if (ckc == ck_dly) ck_d = 1'b1; else begin ck_d = 1'b0; ckc++; end
        end else begin ck_d = 1'b0; ckc = 0; end

        if (clr_model) begin
            ph = 0; cnt = 0; busy_m = 1'b0;
        end else begin
            case (ph)
                0: if (bus.dut_run) begin ph = 1; cnt = bz_dly; end
                1: begin cnt--; if (cnt == 0) begin busy_m = 1'b1; cnt = bz_len; ph = 2; end end
                2: if (!hang) begin cnt--; if (cnt == 0) begin busy_m = 1'b0; ph = 3; end end
                default: if (!bus.dut_run) ph = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_start(input int n, input int to);
        num_rounds     = ROUND_W'(n);
        timeout_cycles = CYCLE_W'(to);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin step(); cyc++; end
        chk("wait_done", done, 1);
    endtask

    task automatic reset_model();
        clr_model = 1;
        step();
        clr_model = 0;
    endtask

    // Cycles one round spends in busy states: load, settle, one idle check,
    // run+compute, check
    function automatic int per_round();
        return (ld_dly + 1) + SETTLE + 1 + (bz_dly + bz_len + 1) + (ck_dly + 1);
    endfunction

    // Full sequence of n rounds with the current model configuration
    task automatic run_seq(input string tag, input int n);
        int b_ld, b_ck, b_v, b_ov, cyc, exp_tot;
        b_ld = n_load; b_ck = n_check; b_v = n_valid; b_ov = n_overlap;
        exp_tot = n * per_round();
        do_start(n, 0);
        wait_done(exp_tot + 100, cyc);
        chk({tag, "_loads"},  n_load - b_ld, n);
        chk({tag, "_checks"}, n_check - b_ck, n);
        chk({tag, "_valids"}, n_valid - b_v, n);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_idx"}, idx_at[b_ld + k], k);
            chk({tag, "_rcyc"}, rc_at[b_v + k], bz_dly + bz_len + 1);
        end
        chk({tag, "_total"}, total_cycles, exp_tot);
        chk({tag, "_latency"}, cyc, exp_tot);
        chk({tag, "_flags"}, {seq_busy, timeout_err, done}, 3'b001);
        chk({tag, "_overlap"}, n_overlap - b_ov, 0);
    endtask

    initial begin
        int cyc, bad, b_ld, b_v;

        repeat (3) step();
        chk("reset_ctrl", {bus.load_req, bus.dut_run, bus.check_req, seq_busy, done,
                           timeout_err, round_valid}, 0);
        chk("reset_cnt", {round_idx, round_cycles, total_cycles}, 0);
        reset_b = 1'b1;
        step();

        // single round, fixed DUT timing
        ld_dly = 0; ck_dly = 0; bz_dly = 1; bz_len = 10; spur = 0;
        run_seq("one_round", 1);
        chk("one_round_rc12", round_cycles, 12);

        // three rounds, late check_done, spurious check_done while running
        ck_dly = 4; ld_dly = 2; bz_dly = 2; bz_len = 7; spur = 1;
        run_seq("three_rounds", 3);
        spur = 0;

        // randomized configurations
        for (int t = 0; t < 4; t++) begin
            ld_dly = $urandom_range(0, 3);
            ck_dly = $urandom_range(0, 4);
            bz_dly = $urandom_range(1, 3);
            bz_len = $urandom_range(1, 12);
            spur   = 1'($urandom_range(0, 1));
            run_seq("rand", $urandom_range(1, 4));
        end
        spur = 0;

        // zero rounds: done right away, no load
        b_ld = n_load;
        do_start(0, 0);
        chk("zero_done", done, 1);
        chk("zero_total_le1", total_cycles <= 1, 1);
        repeat (5) step();
        chk("zero_noload", n_load - b_ld, 0);

        // timeout lands exactly on the last check_done: abort wins
        ld_dly = 0; ck_dly = 0; bz_dly = 1; bz_len = 10;
        do_start(1, per_round());
        wait_done(100, cyc);
        chk("tmo_edge_err", timeout_err, 1);
        chk("tmo_edge_total", total_cycles, per_round());
        // one cycle more of budget completes normally
        do_start(1, per_round() + 1);
        wait_done(100, cyc);
        chk("tmo_edge1_err", timeout_err, 0);

        // DUT hangs busy: abort at 50
        hang = 1;
        do_start(2, 50);
        wait_done(200, cyc);
        chk("tmo_latency", cyc, 50);
        chk("tmo_total", total_cycles, 50);
        chk("tmo_flags", {timeout_err, done, seq_busy}, 3'b110);
        chk("tmo_outs", {bus.dut_run, bus.load_req, bus.check_req}, 0);
        hang = 0;
        reset_model();
        do_start(1, 0);
        chk("restart_flags", {timeout_err, done}, 0);
        chk("restart_idx", {bus.load_req, round_idx}, {1'b1, 8'd0});
        wait_done(200, cyc);
        chk("restart_total", total_cycles, per_round());

        // busy held through WAIT_IDLE, start pulse ignored mid-sequence
        b_v = n_valid;
        force_busy = 1;
        do_start(1, 0);
        bad = 0;
        for (int i = 0; i < 26; i++) begin
            if (bus.dut_run !== 1'b0) bad++;
            num_rounds = '0;
            start = (i == 10);
            step();
        end
        start = 1'b0;
        chk("hold_no_run", bad, 0);
        chk("hold_busy", seq_busy, 1);
        force_busy = 0;
        wait_done(200, cyc);
        chk("hold_total", total_cycles, per_round() + 20);
        chk("hold_valids", n_valid - b_v, 1);

        // async reset in the middle of COMPUTE of round 1
        do_start(3, 0);
        cyc = 0;
        while (!(round_idx === 8'd1 && ph == 2 && bus.dut_run === 1'b0) && cyc < 500) begin
            step(); cyc++;
        end
        chk("rst_reach_compute", cyc < 500, 1);
        step();
        #2 reset_b = 1'b0;
        #1;
        chk("rst_async_ctrl", {bus.load_req, bus.dut_run, bus.check_req, seq_busy, done,
                               timeout_err, round_valid}, 0);
        chk("rst_async_cnt", {round_idx, round_cycles, total_cycles}, 0);
        reset_model();
        reset_b = 1'b1;
        step();
        b_v = n_valid;
        do_start(1, 0);
        chk("post_rst_idx", {bus.load_req, round_idx}, {1'b1, 8'd0});
        wait_done(200, cyc);
        chk("post_rst_total", total_cycles, per_round());
        chk("post_rst_rc", round_cycles, bz_dly + bz_len + 1);
        chk("post_rst_valids", n_valid - b_v, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
